// File: rtl/div_seq_ctrl.sv
// Sequencer between the EXE stage and a multi-cycle divider core with split dividend/divisor
// stream channels; holds the selected quotient/remainder until EXE advances, drains on flush.
module div_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_src1,
    input  logic [WIDTH-1:0] req_src2,
    input  logic             flush,
    input  logic             res_ready,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic             dvd_tvalid,
    input  logic             dvd_tready,
    output logic             dvs_tvalid,
    input  logic             dvs_tready,
    output logic             div_signed,
    output logic [WIDTH-1:0] div_dividend,
    output logic [WIDTH-1:0] div_divisor,
    input  logic             dout_tvalid,
    input  logic [WIDTH-1:0] dout_quot,
    input  logic [WIDTH-1:0] dout_rem,
    output logic [CNT_W-1:0] busy_cycles
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

    state_e           state_q, state_d;
    logic             rem_sel_q, rem_sel_d;
    logic             signed_q, signed_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             dvd_done_q, dvd_done_d;
    logic             dvs_done_q, dvs_done_d;
    logic             killed_q, killed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic dvd_fin, dvs_fin;

    assign dvd_tvalid   = (state_q == ISSUE) && !dvd_done_q;
    assign dvs_tvalid   = (state_q == ISSUE) && !dvs_done_q;
    assign dvd_fin      = dvd_done_q || (dvd_tvalid && dvd_tready);
    assign dvs_fin      = dvs_done_q || (dvs_tvalid && dvs_tready);

    assign res_valid    = (state_q == DONE);
    assign res_data     = res_q;
    assign div_signed   = signed_q;
    assign div_dividend = dvd_q;
    assign div_divisor  = dvs_q;
    assign busy_cycles  = cnt_q;

    always_comb begin
        // NOTE: every signal is given its hold value first, so no path through the case can infer a latch.
        state_d    = state_q;
        rem_sel_d  = rem_sel_q;
        signed_d   = signed_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        res_d      = res_q;
        dvd_done_d = dvd_done_q;
        dvs_done_d = dvs_done_q;
        killed_d   = killed_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid && !flush) begin
                    rem_sel_d  = req_op[0];
                    signed_d   = !req_op[1];
                    dvd_d      = req_src1;
                    dvs_d      = req_src2;
                    dvd_done_d = 1'b0;
                    dvs_done_d = 1'b0;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                dvd_done_d = dvd_fin;
                dvs_done_d = dvs_fin;
                // Once either operand reached the core the stream cannot be withdrawn.
                if (flush && !dvd_fin && !dvs_fin) begin
                    state_d = IDLE;
                end else begin
                    if (flush) killed_d = 1'b1;
                    if (dvd_fin && dvs_fin) state_d = WAIT;
                end
            end
            WAIT: begin
                if (flush) killed_d = 1'b1;
                if (dout_tvalid) begin
                    if (killed_q || flush) begin
                        state_d = IDLE;
                    end else begin
                        res_d   = rem_sel_q ? dout_rem : dout_quot;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (flush || res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_d == IDLE) killed_d = 1'b0;

        if (state_q == IDLE || state_d == IDLE) cnt_d = '0;
        else if (&cnt_q)                        cnt_d = cnt_q;
        else                                    cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rem_sel_q  <= 1'b0;
            signed_q   <= 1'b0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            res_q      <= '0;
            dvd_done_q <= 1'b0;
            dvs_done_q <= 1'b0;
            killed_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge value of the others.
            state_q    <= state_d;
            rem_sel_q  <= rem_sel_d;
            signed_q   <= signed_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            res_q      <= res_d;
            dvd_done_q <= dvd_done_d;
            dvs_done_q <= dvs_done_d;
            killed_q   <= killed_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Bench for div_seq_ctrl: a behavioural divider core with programmable tready delays and latency,
// directed scenarios plus randomized transactions checked against plain-arithmetic expectations.
module tb_div_seq_ctrl;

    localparam int W       = 32;
    localparam int CW      = 6;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic [1:0]    req_op;
    logic [W-1:0]  req_src1, req_src2;
    logic          flush, res_ready;
    logic          res_valid;
    logic [W-1:0]  res_data;
    logic          dvd_tvalid, dvd_tready, dvs_tvalid, dvs_tready;
    logic          div_signed;
    logic [W-1:0]  div_dividend, div_divisor;
    logic          dout_tvalid;
    logic [W-1:0]  dout_quot, dout_rem;
    logic [CW-1:0] busy_cycles;

    // Core model drives core_*; tests can inject a stray result pulse through inj_*.
    logic          core_tvalid, inj_tvalid;
    logic [W-1:0]  core_quot, core_rem, inj_quot, inj_rem;
    assign dout_tvalid = core_tvalid | inj_tvalid;
    assign dout_quot   = inj_tvalid ? inj_quot : core_quot;
    assign dout_rem    = inj_tvalid ? inj_rem  : core_rem;

    int checks = 0;
    int errors = 0;
    int dvd_delay, dvs_delay, core_lat;
    int core_done;
    int rv_seen;

    div_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_op(req_op), .req_src1(req_src1), .req_src2(req_src2),
        .flush(flush), .res_ready(res_ready), .res_valid(res_valid), .res_data(res_data),
        .dvd_tvalid(dvd_tvalid), .dvd_tready(dvd_tready),
        .dvs_tvalid(dvs_tvalid), .dvs_tready(dvs_tready),
        .div_signed(div_signed), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .dout_tvalid(dout_tvalid), .dout_quot(dout_quot), .dout_rem(dout_rem),
        .busy_cycles(busy_cycles)
    );

    always #5 clk = ~clk;

    // Core arithmetic: divide by zero gives all-ones quotient and the dividend as remainder.
    function automatic void divmod(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] q, output logic [W-1:0] r);
        int sa, sb;
        sa = a;
        sb = b;
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (sgn && a == 32'h8000_0000 && b == '1) begin
            q = a;
            r = '0;
        end else if (sgn) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    initial begin : core_model
        bit           rst_s, dvd_got, dvs_got, sgn;
        int           dvd_n, dvs_n, cd;
        logic [W-1:0] a, b, q, r;
        dvd_tready = 1'b0; dvs_tready = 1'b0;
        core_tvalid = 1'b0; core_quot = '0; core_rem = '0; core_done = 0;
        dvd_got = 1'b0; dvs_got = 1'b0; dvd_n = 0; dvs_n = 0; cd = -1;
        sgn = 1'b0; a = '0; b = '0;
        forever begin
            @(posedge clk);
            rst_s = reset;
            @(negedge clk);
            core_tvalid = 1'b0;
            dvd_tready  = 1'b0;
            dvs_tready  = 1'b0;
            if (rst_s) begin
                dvd_got = 1'b0; dvs_got = 1'b0; dvd_n = 0; dvs_n = 0; cd = -1;
            end else begin
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        divmod(sgn, a, b, q, r);
                        core_tvalid = 1'b1; core_quot = q; core_rem = r;
                        core_done++;
                        cd = -1;
                    end
                end
                if (!dvd_tvalid && !dvd_got) dvd_n = 0;
                if (!dvs_tvalid && !dvs_got) dvs_n = 0;
                if (dvd_tvalid && !dvd_got) begin
                    if (dvd_n >= dvd_delay) begin
                        dvd_tready = 1'b1; dvd_got = 1'b1; a = div_dividend; sgn = div_signed;
                    end else dvd_n++;
                end
                if (dvs_tvalid && !dvs_got) begin
                    if (dvs_n >= dvs_delay) begin
                        dvs_tready = 1'b1; dvs_got = 1'b1; b = div_divisor;
                    end else dvs_n++;
                end
                if (dvd_got && dvs_got) begin
                    cd = core_lat;
                    dvd_got = 1'b0; dvs_got = 1'b0; dvd_n = 0; dvs_n = 0;
                end
            end
        end
    end

    initial begin : res_valid_monitor
        rv_seen = 0;
        forever begin
            @(negedge clk);
            if (res_valid === 1'b1) rv_seen++;
        end
    end

    // One full transaction from request to release; request inputs are scrambled while busy.
    task automatic run_txn(input string name, input logic [1:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input int dd, input int ds, input int lat,
                           input int hold, input bit end_flush);
        logic [W-1:0] q, r, exp_res, held;
        int cyc, exp_lat, exp_busy;
        bit got;
        divmod(!op[1], a, b, q, r);
        exp_res  = op[0] ? r : q;
        exp_lat  = 2 + ((dd > ds) ? dd : ds) + lat;
        exp_busy = (exp_lat - 1 > CNT_MAX) ? CNT_MAX : exp_lat - 1;
        dvd_delay = dd; dvs_delay = ds; core_lat = lat;
        req_valid = 1'b1; req_op = op; req_src1 = a; req_src2 = b;
        res_ready = 1'b0; flush = 1'b0;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                checks++;
                if (div_dividend !== a || div_divisor !== b || div_signed !== !op[1] || dvd_tvalid !== 1'b1) begin
                    errors++;
                    $display("FAIL %s issue: dividend=%h divisor=%h signed=%b dvd_tvalid=%b, expected %h %h %b 1",
                             name, div_dividend, div_divisor, div_signed, dvd_tvalid, a, b, !op[1]);
                end
            end
            got = (res_valid === 1'b1);
            req_op = 2'($urandom); req_src1 = $urandom; req_src2 = $urandom;
        end
        checks++;
        if (!got || cyc != exp_lat) begin
            errors++;
            $display("FAIL %s latency: res_valid=%b after %0d cycles, expected 1 after %0d", name, got, cyc, exp_lat);
        end
        checks++;
        if (res_data !== exp_res) begin
            errors++;
            $display("FAIL %s result: res_data=%h, expected %h", name, res_data, exp_res);
        end
        checks++;
        if (busy_cycles !== CW'(exp_busy)) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d, expected %0d", name, busy_cycles, exp_busy);
        end
        held = res_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b1 || res_data !== held) begin
                errors++;
                $display("FAIL %s hold %0d: res_valid=%b res_data=%h, expected 1 %h", name, i, res_valid, res_data, held);
            end
        end
        if (end_flush) begin
            flush = 1'b1;
            res_ready = 1'($urandom_range(0, 1));
        end else begin
            res_ready = 1'b1;
        end
        @(negedge clk);
        flush = 1'b0; res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || busy_cycles !== '0 || dvd_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL %s release: res_valid=%b busy=%0d dvd_tvalid=%b, expected 0 0 0",
                     name, res_valid, busy_cycles, dvd_tvalid);
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({res_valid, dvd_tvalid, dvs_tvalid, div_signed, busy_cycles} !== '0 ||
            res_data !== '0 || div_dividend !== '0 || div_divisor !== '0) begin
            errors++;
            $display("FAIL reset: valid=%b dvd=%b dvs=%b signed=%b busy=%0d data=%h dvd=%h dvs=%h, expected all 0",
                     res_valid, dvd_tvalid, dvs_tvalid, div_signed, busy_cycles, res_data, div_dividend, div_divisor);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        run_txn("div_w_neg",     2'b00, 32'hFFFF_FFF9, 32'h2,  0, 0, 8, 0, 1'b0);
        run_txn("mod_wu_stagger", 2'b11, 32'hFFFF_FFFF, 32'h10, 0, 1, 4, 0, 1'b0);
        run_txn("done_hold",     2'b01, 32'h8000_0007, 32'h3,  1, 0, 3, 5, 1'b0);
        run_txn("div_wu_zero",   2'b10, 32'd123,       32'h0,  2, 2, 2, 1, 1'b0);
        run_txn("mod_w_zero",    2'b01, 32'hDEAD_BEEF, 32'h0,  0, 0, 1, 0, 1'b0);
        run_txn("flush_done",    2'b00, 32'd1000,      32'd7,  0, 0, 2, 2, 1'b1);
        run_txn("busy_sat",      2'b10, 32'd77,        32'd5,  0, 0, 70, 0, 1'b0);
    endtask

    task automatic test_flush_wait();
        int rv0, done0;
        rv0 = rv_seen; done0 = core_done;
        dvd_delay = 0; dvs_delay = 0; core_lat = 5;
        req_valid = 1'b1; req_op = 2'b00; req_src1 = 32'd100; req_src2 = 32'd7;
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy_cycles !== CW'(5)) begin
            errors++;
            $display("FAIL flush_wait hold: busy=%0d, expected 5", busy_cycles);
        end
        @(negedge clk);
        checks++;
        if (busy_cycles !== '0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_wait drain: busy=%0d res_valid=%b, expected 0 0", busy_cycles, res_valid);
        end
        @(negedge clk);
        checks++;
        if (rv_seen != rv0 || core_done != done0 + 1) begin
            errors++;
            $display("FAIL flush_wait silent: res_valid cycles=%0d core results=%0d, expected 0 1",
                     rv_seen - rv0, core_done - done0);
        end
        run_txn("after_flush_wait", 2'b10, 32'd100, 32'd7, 0, 0, 3, 0, 1'b0);
    endtask

    task automatic test_flush_issue_partial();
        int rv0, done0;
        rv0 = rv_seen; done0 = core_done;
        dvd_delay = 0; dvs_delay = 3; core_lat = 2;
        req_valid = 1'b1; req_op = 2'b01; req_src1 = 32'd50; req_src2 = 32'd6;
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk); flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dvd_tvalid !== 1'b0 || dvs_tvalid !== 1'b1) begin
                errors++;
                $display("FAIL flush_issue_partial channel %0d: dvd_tvalid=%b dvs_tvalid=%b, expected 0 1",
                         i, dvd_tvalid, dvs_tvalid);
            end
            @(negedge clk); flush = 1'b0;
        end
        checks++;
        if (dvs_tvalid !== 1'b0 || busy_cycles !== CW'(4)) begin
            errors++;
            $display("FAIL flush_issue_partial wait: dvs_tvalid=%b busy=%0d, expected 0 4", dvs_tvalid, busy_cycles);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (busy_cycles !== '0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_issue_partial drain: busy=%0d res_valid=%b, expected 0 0", busy_cycles, res_valid);
        end
        @(negedge clk);
        checks++;
        if (rv_seen != rv0 || core_done != done0 + 1) begin
            errors++;
            $display("FAIL flush_issue_partial silent: res_valid cycles=%0d core results=%0d, expected 0 1",
                     rv_seen - rv0, core_done - done0);
        end
    endtask

    task automatic test_flush_issue_none();
        int rv0, done0;
        rv0 = rv_seen; done0 = core_done;
        dvd_delay = 3; dvs_delay = 3; core_lat = 2;
        req_valid = 1'b1; req_op = 2'b00; req_src1 = 32'd9; req_src2 = 32'd3;
        @(negedge clk); req_valid = 1'b0; flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        checks++;
        if (dvd_tvalid !== 1'b0 || dvs_tvalid !== 1'b0 || busy_cycles !== '0) begin
            errors++;
            $display("FAIL flush_issue_none: dvd_tvalid=%b dvs_tvalid=%b busy=%0d, expected 0 0 0",
                     dvd_tvalid, dvs_tvalid, busy_cycles);
        end
        repeat (8) @(negedge clk);
        checks++;
        if (rv_seen != rv0 || core_done != done0) begin
            errors++;
            $display("FAIL flush_issue_none core: res_valid cycles=%0d core results=%0d, expected 0 0",
                     rv_seen - rv0, core_done - done0);
        end
    endtask

    task automatic test_reset_wait();
        int rv0, done0;
        rv0 = rv_seen; done0 = core_done;
        dvd_delay = 0; dvs_delay = 0; core_lat = 6;
        req_valid = 1'b1; req_op = 2'b00; req_src1 = 32'hFFFF_0000; req_src2 = 32'd17;
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        checks++;
        if ({res_valid, dvd_tvalid, dvs_tvalid, div_signed, busy_cycles} !== '0 ||
            res_data !== '0 || div_dividend !== '0 || div_divisor !== '0) begin
            errors++;
            $display("FAIL reset_wait: valid=%b dvd=%b dvs=%b signed=%b busy=%0d data=%h dvd=%h dvs=%h, expected all 0",
                     res_valid, dvd_tvalid, dvs_tvalid, div_signed, busy_cycles, res_data, div_dividend, div_divisor);
        end
        inj_tvalid = 1'b1; inj_quot = $urandom; inj_rem = $urandom;
        @(negedge clk); inj_tvalid = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (rv_seen != rv0 || core_done != done0 || busy_cycles !== '0) begin
            errors++;
            $display("FAIL reset_wait stray: res_valid cycles=%0d core results=%0d busy=%0d, expected 0 0 0",
                     rv_seen - rv0, core_done - done0, busy_cycles);
        end
        run_txn("after_reset", 2'b11, 32'd1000, 32'd33, 1, 2, 2, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [1:0]   op;
        logic [W-1:0] a, b;
        for (int n = 0; n < 30; n++) begin
            op = 2'($urandom);
            a  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 40)) : $urandom;
            case ($urandom_range(0, 7))
                0:       b = '0;
                1:       b = '1;
                2, 3:    b = W'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            run_txn("random", op, a, b, $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(1, 6), $urandom_range(0, 3), $urandom_range(0, 5) == 0);
        end
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_op = '0; req_src1 = '0; req_src2 = '0;
        flush = 1'b0; res_ready = 1'b0;
        inj_tvalid = 1'b0; inj_quot = '0; inj_rem = '0;
        dvd_delay = 0; dvs_delay = 0; core_lat = 1;
        test_reset();
        test_directed();
        test_flush_wait();
        test_flush_issue_partial();
        test_flush_issue_none();
        test_reset_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
